game_sequencer: RTL and testbench

Round sequencer for the decimal-to-binary quiz. It sits between the debounced submit button, the random number generator and the LED/seven-segment display path. It steps the game through idle, number generation, timed play, level advance and end states. It owns the level counter, the 16-LED countdown bar (step period shrinks with level) and the one-cycle number-generate strobe.

---
 rtl/game_sequencer.sv | 125 ++++++++++++
 tb/tb_game_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Round sequencer for the decimal-to-binary quiz: level, countdown bar,
// score and the new-number strobe.
module game_sequencer #(
  parameter int STEP_BASE = 50_000_000,
  parameter int STEP_DEC  = 4_000_000,
  parameter int MAX_LEVEL = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        submit,
  input  logic        correct,
  output logic        num_gen,
  output logic [3:0]  level,
  output logic [15:0] leds,
  output logic [7:0]  score,
  output logic        game_over,
  output logic        game_won
);

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    PLAY,
    ADV,
    LOSE,
    WIN
  } state_t;

  localparam logic [31:0] BASE = 32'(STEP_BASE);
  localparam logic [31:0] DEC  = 32'(STEP_DEC);
  localparam logic [3:0]  LMAX = 4'(MAX_LEVEL);

  state_t      state, state_d;
  logic [15:0] leds_d;
  logic [3:0]  level_d;
  logic [7:0]  score_d;
  logic [31:0] cnt, cnt_d;
  logic [31:0] step_len;
  logic        submit_q;
  logic        sub_edge;

  assign sub_edge = submit & ~submit_q;
  assign step_len = BASE - (32'(level) - 32'd1) * DEC;

  assign num_gen   = (state == GEN);
  assign game_over = (state == LOSE);
  assign game_won  = (state == WIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      leds     <= '0;
      level    <= 4'd1;
      score    <= '0;
      cnt      <= '0;
      submit_q <= 1'b1;
    end else begin
      state    <= state_d;
      leds     <= leds_d;
      level    <= level_d;
      score    <= score_d;
      cnt      <= cnt_d;
      submit_q <= submit;
    end
  end

  always_comb begin
    state_d = state;
    leds_d  = leds;
    level_d = level;
    score_d = score;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        leds_d  = '0;
        level_d = 4'd1;
        score_d = '0;
        cnt_d   = '0;
        if (sub_edge)
          state_d = GEN;
      end
      GEN: begin
        leds_d  = '1;
        cnt_d   = '0;
        state_d = PLAY;
      end
      PLAY: begin
        if (sub_edge && correct) begin
          if (score != 8'hFF)
            score_d = score + 8'd1;
          state_d = ADV;
        end else begin
          // a penalty shift also swallows a coinciding step expiry
          if (sub_edge || (cnt == step_len - 32'd1)) begin
            leds_d = leds >> 1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt + 32'd1;
          end
          if (leds_d == '0)
            state_d = LOSE;
        end
      end
      ADV: begin
        if (level == LMAX) begin
          state_d = WIN;
        end else begin
          level_d = level + 4'd1;
          state_d = GEN;
        end
      end
      LOSE, WIN: begin
        if (sub_edge) begin
          leds_d  = '0;
          level_d = 4'd1;
          score_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with STEP_BASE=10, STEP_DEC=2,
// MAX_LEVEL=3.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        submit;
  logic        correct;
  logic        num_gen;
  logic [3:0]  level;
  logic [15:0] leds;
  logic [7:0]  score;
  logic        game_over;
  logic        game_won;

  int total = 0;
  int bad   = 0;

  game_sequencer #(
    .STEP_BASE(10),
    .STEP_DEC (2),
    .MAX_LEVEL(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .submit   (submit),
    .correct  (correct),
    .num_gen  (num_gen),
    .level    (level),
    .leds     (leds),
    .score    (score),
    .game_over(game_over),
    .game_won (game_won)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    submit  = 1'b1;
    correct = 1'b0;
    tick(3);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_level", 32'(level), 32'd1);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_numgen", 32'(num_gen), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_won", 32'(game_won), 32'd0);

    // submit held through reset: no edge
    reset = 1'b0;
    tick(3);
    chk("held_numgen", 32'(num_gen), 32'd0);
    chk("held_leds", 32'(leds), 32'h0);
    submit = 1'b0;
    tick(1);
    submit = 1'b1;
    tick(1);
    chk("gen_pulse", 32'(num_gen), 32'd1);
    submit = 1'b0;
    tick(1);
    chk("gen_single", 32'(num_gen), 32'd0);
    chk("play_full", 32'(leds), 32'hFFFF);

    // level 1 timeout, step_len = 10
    tick(9);
    chk("l1_pre_step", 32'(leds), 32'hFFFF);
    tick(1);
    chk("l1_step", 32'(leds), 32'h7FFF);
    tick(149);
    chk("l1_last_led", 32'(leds), 32'h0001);
    chk("l1_not_over", 32'(game_over), 32'd0);
    tick(1);
    chk("l1_lose_leds", 32'(leds), 32'h0);
    chk("l1_lose", 32'(game_over), 32'd1);
    tick(3);
    chk("lose_hold", 32'(game_over), 32'd1);

    submit = 1'b1;
    tick(1);
    chk("lose_idle", 32'(game_over), 32'd0);
    chk("lose_idle_lvl", 32'(level), 32'd1);
    submit = 1'b0;
    tick(1);

    // correct at level 1
    submit = 1'b1;
    tick(1);
    submit = 1'b0;
    tick(1);
    chk("g2_full", 32'(leds), 32'hFFFF);
    submit  = 1'b1;
    correct = 1'b1;
    tick(1);
    chk("adv_score", 32'(score), 32'd1);
    chk("adv_level", 32'(level), 32'd1);
    chk("adv_numgen", 32'(num_gen), 32'd0);
    submit  = 1'b0;
    correct = 1'b0;
    tick(1);
    chk("l2_level", 32'(level), 32'd2);
    chk("l2_numgen", 32'(num_gen), 32'd1);
    tick(1);
    chk("l2_full", 32'(leds), 32'hFFFF);
    tick(7);
    chk("l2_pre_step", 32'(leds), 32'hFFFF);
    tick(1);
    chk("l2_step1", 32'(leds), 32'h7FFF);
    tick(8);
    chk("l2_step2", 32'(leds), 32'h3FFF);

    // penalty on the same cycle as a step expiry
    tick(48);
    chk("pen_setup", 32'(leds), 32'h00FF);
    tick(7);
    chk("pen_pre", 32'(leds), 32'h00FF);
    submit = 1'b1;
    tick(1);
    chk("pen_single", 32'(leds), 32'h007F);
    submit = 1'b0;
    tick(7);
    chk("pen_restart", 32'(leds), 32'h007F);
    tick(1);
    chk("pen_next", 32'(leds), 32'h003F);

    // levels 2 and 3 correct -> WIN
    submit  = 1'b1;
    correct = 1'b1;
    tick(1);
    chk("l2_adv_score", 32'(score), 32'd2);
    submit  = 1'b0;
    correct = 1'b0;
    tick(1);
    chk("l3_level", 32'(level), 32'd3);
    tick(1);
    chk("l3_full", 32'(leds), 32'hFFFF);
    submit  = 1'b1;
    correct = 1'b1;
    tick(1);
    chk("l3_adv_score", 32'(score), 32'd3);
    submit  = 1'b0;
    correct = 1'b0;
    tick(1);
    chk("win", 32'(game_won), 32'd1);
    chk("win_level", 32'(level), 32'd3);
    chk("win_score", 32'(score), 32'd3);
    chk("win_leds", 32'(leds), 32'hFFFF);
    chk("win_numgen", 32'(num_gen), 32'd0);
    tick(3);
    chk("win_hold", 32'(game_won), 32'd1);
    chk("win_leds_hold", 32'(leds), 32'hFFFF);
    submit = 1'b1;
    tick(1);
    chk("win_idle", 32'(game_won), 32'd0);
    chk("win_idle_lvl", 32'(level), 32'd1);
    chk("win_idle_score", 32'(score), 32'd0);
    chk("win_idle_leds", 32'(leds), 32'h0);
    submit = 1'b0;
    tick(1);

    // reset mid-round at level 2 with leds = 0FFF
    submit = 1'b1;
    tick(1);
    submit = 1'b0;
    tick(1);
    submit  = 1'b1;
    correct = 1'b1;
    tick(1);
    submit  = 1'b0;
    correct = 1'b0;
    tick(2);
    chk("r_play_lvl", 32'(level), 32'd2);
    tick(32);
    chk("r_setup", 32'(leds), 32'h0FFF);
    reset = 1'b1;
    tick(1);
    chk("r_leds", 32'(leds), 32'h0);
    chk("r_level", 32'(level), 32'd1);
    chk("r_score", 32'(score), 32'd0);
    chk("r_numgen", 32'(num_gen), 32'd0);
    chk("r_over", 32'(game_over), 32'd0);
    reset = 1'b0;
    tick(2);
    chk("r_idle_numgen", 32'(num_gen), 32'd0);
    chk("r_idle_leds", 32'(leds), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
